// File: rtl/rhythm_score_engine.sv
// Rhythm-game scoring engine: per-pattern rise/fall score window, saturating score,
// hit/miss strobes, combo counter. Define SCORE_COMBO_EN to enable the combo multiplier.
module rhythm_score_engine #(
  parameter int PAT_W    = 8,
  parameter int WIN_W    = 3,
  parameter int PEAK     = 4,
  parameter int SCORE_W  = 11,
  parameter int COMBO_W  = 8,
  parameter int MULT_MAX = 4
) (
  input  logic               counter10h,
  input  logic               reset,
  input  logic [PAT_W-1:0]   pattern,
  input  logic [PAT_W-1:0]   user_input,
  output logic [SCORE_W-1:0] score_out,
  output logic               hit,
  output logic               miss,
  output logic [SCORE_W-1:0] last_points,
  output logic [COMBO_W-1:0] combo,
  output logic [1:0]         state
);

  localparam int EXT_W = SCORE_W + WIN_W + 3;
  localparam logic [WIN_W-1:0]   PEAK_C    = WIN_W'(PEAK);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
  localparam logic [COMBO_W-1:0] COMBO_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RISE   = 2'd1,
    ST_FALL   = 2'd2,
    ST_LOCKED = 2'd3
  } state_e;

  if (PEAK < 1 || PEAK > (2 ** WIN_W) - 1 || MULT_MAX < 1) begin : g_bad_params
    $error("rhythm_score_engine: PEAK or MULT_MAX out of range");
  end

  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] base,
                                                 input logic [EXT_W-1:0]   incr);
    logic [EXT_W-1:0] sum;
    sum = EXT_W'(base) + incr;
    if (sum > EXT_W'(SCORE_MAX)) begin
      return SCORE_MAX;
    end else begin
      return sum[SCORE_W-1:0];
    end
  endfunction

  function automatic logic [COMBO_W-1:0] combo_inc(input logic [COMBO_W-1:0] c);
    if (c == COMBO_MAX) begin
      return c;
    end else begin
      return c + COMBO_W'(1);
    end
  endfunction

  logic [PAT_W-1:0]   cur_pat_r,     cur_pat_s;
  logic [WIN_W-1:0]   window_r,      window_s;
  state_e             state_r,       state_s;
  logic [SCORE_W-1:0] score_r,       score_s;
  logic [COMBO_W-1:0] combo_r,       combo_s;
  logic [SCORE_W-1:0] last_points_r, last_points_s;
  logic               hit_r,         hit_s;
  logic               miss_r,        miss_s;
  logic [EXT_W-1:0]   points_s;

`ifdef SCORE_COMBO_EN
  localparam int MC_W = COMBO_W + 1;
  logic [MC_W-1:0]  mult_raw_s;
  logic [EXT_W-1:0] mult_s;

  // Multiplier from the combo count held before this hit's increment
  always_comb begin
    mult_raw_s = {1'b0, combo_r >> 2} + MC_W'(1);
    if (mult_raw_s > MC_W'(MULT_MAX)) begin
      mult_s = EXT_W'(MULT_MAX);
    end else begin
      mult_s = EXT_W'(mult_raw_s);
    end
    points_s = EXT_W'(window_r) * mult_s;
  end
`else
  // Points equal the current window value
  always_comb begin
    points_s = EXT_W'(window_r);
  end
`endif

  // Next-state and output decode; pattern change outranks a match on the same edge
  always_comb begin
    cur_pat_s     = cur_pat_r;
    window_s      = window_r;
    state_s       = state_r;
    score_s       = score_r;
    combo_s       = combo_r;
    last_points_s = last_points_r;
    hit_s         = 1'b0;
    miss_s        = 1'b0;

    if (pattern != cur_pat_r) begin
      cur_pat_s = pattern;
      window_s  = '0;
      if (pattern != '0) begin
        state_s = ST_RISE;
      end else begin
        state_s = ST_IDLE;
      end
      if (state_r == ST_RISE || state_r == ST_FALL) begin
        miss_s  = 1'b1;
        combo_s = '0;
      end else begin
        miss_s  = 1'b0;
      end
    end else begin
      case (state_r)
        ST_RISE, ST_FALL: begin
          if (user_input == cur_pat_r) begin
            score_s       = sat_add(score_r, points_s);
            last_points_s = sat_add('0, points_s);
            combo_s       = combo_inc(combo_r);
            hit_s         = 1'b1;
            state_s       = ST_LOCKED;
          end else if (state_r == ST_RISE) begin
            window_s = window_r + WIN_W'(1);
            if ((window_r + WIN_W'(1)) == PEAK_C) begin
              state_s = ST_FALL;
            end else begin
              state_s = ST_RISE;
            end
          end else if (window_r == '0) begin
            miss_s  = 1'b1;
            combo_s = '0;
            state_s = ST_IDLE;
          end else begin
            window_s = window_r - WIN_W'(1);
          end
        end
        default: begin
          state_s = state_r;
        end
      endcase
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge counter10h) begin
    if (reset) begin
      cur_pat_r     <= '0;
      window_r      <= '0;
      state_r       <= ST_IDLE;
      score_r       <= '0;
      combo_r       <= '0;
      last_points_r <= '0;
      hit_r         <= 1'b0;
      miss_r        <= 1'b0;
    end else begin
      cur_pat_r     <= cur_pat_s;
      window_r      <= window_s;
      state_r       <= state_s;
      score_r       <= score_s;
      combo_r       <= combo_s;
      last_points_r <= last_points_s;
      hit_r         <= hit_s;
      miss_r        <= miss_s;
    end
  end

  assign score_out   = score_r;
  assign hit         = hit_r;
  assign miss        = miss_r;
  assign last_points = last_points_r;
  assign combo       = combo_r;
  assign state       = state_r;

endmodule

// File: tb/tb_rhythm_score_engine.sv
// Scoreboard bench for rhythm_score_engine: stimulus queues expected hit/miss events,
// a negedge monitor pops and compares them; a SCORE_W=4 instance shares the stimulus.
module tb_rhythm_score_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [7:0] pattern, user_input;

  logic [10:0] score_out, last_points;
  logic        hit, miss;
  logic [7:0]  combo;
  logic [1:0]  state;

  logic [3:0] score4, last4;
  logic       hit4, miss4;
  logic [7:0] combo4;
  logic [1:0] state4;

  rhythm_score_engine #(.PAT_W(8), .WIN_W(3), .PEAK(4), .SCORE_W(11), .COMBO_W(8), .MULT_MAX(4)) dut (
    .counter10h(clk), .reset(reset), .pattern(pattern), .user_input(user_input),
    .score_out(score_out), .hit(hit), .miss(miss), .last_points(last_points),
    .combo(combo), .state(state)
  );

  rhythm_score_engine #(.PAT_W(8), .WIN_W(3), .PEAK(4), .SCORE_W(4), .COMBO_W(8), .MULT_MAX(4)) dut4 (
    .counter10h(clk), .reset(reset), .pattern(pattern), .user_input(user_input),
    .score_out(score4), .hit(hit4), .miss(miss4), .last_points(last4),
    .combo(combo4), .state(state4)
  );

  typedef struct {
    logic        is_hit;
    logic [10:0] score;
    logic [10:0] last;
    logic [7:0]  combo;
    logic [1:0]  st;
    logic [3:0]  score4;
    logic [3:0]  last4;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int checks = 0;
  int errors = 0;
  int m_score = 0, m_last = 0, m_combo = 0, m_score4 = 0, m_last4 = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_entry(input logic is_hit, input int st);
    exp_t x;
    x.is_hit = is_hit;
    x.score  = 11'(m_score);
    x.last   = 11'(m_last);
    x.combo  = 8'(m_combo);
    x.st     = 2'(st);
    x.score4 = 4'(m_score4);
    x.last4  = 4'(m_last4);
    q.push_back(x);
  endtask

  task automatic push_hit(input int w);
    int mult, pts;
    mult = 1;
`ifdef SCORE_COMBO_EN
    mult = 1 + (m_combo >> 2);
    if (mult > 4) mult = 4;
`endif
    pts      = w * mult;
    m_score  = (m_score + pts > 2047) ? 2047 : m_score + pts;
    m_score4 = (m_score4 + pts > 15) ? 15 : m_score4 + pts;
    m_last   = pts;
    m_last4  = (pts > 15) ? 15 : pts;
    m_combo  = (m_combo == 255) ? 255 : m_combo + 1;
    push_entry(1'b1, 3);
  endtask

  task automatic push_miss(input int st);
    m_combo = 0;
    push_entry(1'b0, st);
  endtask

  // Latch p, let the window climb to w, then match on the next edge
  task automatic do_hit(input logic [7:0] p, input int w);
    pattern    = p;
    user_input = 8'h00;
    tick();
    repeat (w) tick();
    user_input = p;
    push_hit(w);
    tick();
    user_input = 8'h00;
  endtask

  // Monitor: every hit/miss strobe must match the next queued expectation
  always @(negedge clk) begin
    if (hit || miss || hit4 || miss4) begin
      check("hit_miss_exclusive", int'(hit && miss), 0);
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: hit=%0d miss=%0d with no event expected", hit, miss);
      end else begin
        e = q.pop_front();
        check("ev_hit",    int'(hit),         int'(e.is_hit));
        check("ev_miss",   int'(miss),        int'(!e.is_hit));
        check("ev_score",  int'(score_out),   int'(e.score));
        check("ev_last",   int'(last_points), int'(e.last));
        check("ev_combo",  int'(combo),       int'(e.combo));
        check("ev_state",  int'(state),       int'(e.st));
        check("ev4_hit",   int'(hit4),        int'(e.is_hit));
        check("ev4_miss",  int'(miss4),       int'(!e.is_hit));
        check("ev4_score", int'(score4),      int'(e.score4));
        check("ev4_last",  int'(last4),       int'(e.last4));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    pattern    = 8'h00;
    user_input = 8'h00;
    tick();
    tick();
    check("rst_score", int'(score_out), 0);
    check("rst_state", int'(state), 0);
    check("rst_combo", int'(combo), 0);
    check("rst_last",  int'(last_points), 0);
    check("rst_hit",   int'(hit), 0);
    check("rst_miss",  int'(miss), 0);
    reset = 1'b0;

    // Match at window 3 after latch of 0x81
    pattern = 8'h81;
    tick();
    check("t1_rise", int'(state), 1);
    repeat (3) tick();
    user_input = 8'h81;
    push_hit(3);
    tick();
    check("t1_score", int'(score_out), 3);
    check("t1_last",  int'(last_points), 3);
    check("t1_state", int'(state), 3);
    tick();
    check("t1_hit_pulse", int'(hit), 0);
    repeat (3) tick();
    check("t1_hold_score", int'(score_out), 3);
    check("t1_hold_state", int'(state), 3);

    // Full window with no input: expiry miss on the ninth edge after latch
    user_input = 8'h00;
    pattern    = 8'h3C;
    tick();
    repeat (8) tick();
    check("t2_fall_at_zero", int'(state), 2);
    push_miss(0);
    tick();
    check("t2_idle",  int'(state), 0);
    check("t2_combo", int'(combo), 0);
    check("t2_score", int'(score_out), 3);

    // Replacement with a match on the old pattern: miss, no award
    pattern = 8'h10;
    tick();
    tick();
    pattern    = 8'h20;
    user_input = 8'h10;
    push_miss(1);
    tick();
    check("t3_new_rise", int'(state), 1);
    user_input = 8'h20;
    push_hit(0);
    tick();
    check("t3_zero_pts", int'(last_points), 0);
    check("t3_combo",    int'(combo), 1);
    check("t3_score",    int'(score_out), 3);
    user_input = 8'h00;

    // Build to 14 in the 4-bit instance, then saturate
    do_hit(8'h01, 4);
    do_hit(8'h02, 4);
    do_hit(8'h03, 3);
    check("t4_score4_14", int'(score4), 14);
    check("t4_score_14",  int'(score_out), 14);
    check("t4_combo4",    int'(combo), 4);
    do_hit(8'h04, 3);
    check("t4_score4_sat", int'(score4), 15);
    check("t4_combo5",     int'(combo), 5);
`ifdef SCORE_COMBO_EN
    check("t4_last_mult", int'(last_points), 6);
    check("t4_score_20",  int'(score_out), 20);
`else
    check("t4_last_plain", int'(last_points), 3);
    check("t4_score_17",   int'(score_out), 17);
`endif

    // Reset during FALL at window 2: cleared, no miss
    pattern = 8'h55;
    tick();
    repeat (6) tick();
    check("t5_fall", int'(state), 2);
    reset = 1'b1;
    tick();
    m_score = 0; m_last = 0; m_combo = 0; m_score4 = 0; m_last4 = 0;
    check("t5_score",  int'(score_out), 0);
    check("t5_state",  int'(state), 0);
    check("t5_combo",  int'(combo), 0);
    check("t5_last",   int'(last_points), 0);
    check("t5_miss",   int'(miss), 0);
    check("t5_score4", int'(score4), 0);
    reset = 1'b0;
    tick();
    check("t5_relatch", int'(state), 1);
    repeat (2) tick();
    user_input = 8'h55;
    push_hit(2);
    tick();
    check("t5_post_score", int'(score_out), 2);
    check("t5_post_combo", int'(combo), 1);
    user_input = 8'h00;

    repeat (2) tick();
    check("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rhythm_score_engine.md
# rhythm_score_engine

Parametrised scoring engine for the reaction/rhythm game: tracks the currently displayed target pattern, runs a rise-then-fall score window per pattern, and accumulates a saturating global score when the player's input matches. It adds explicit hit/miss strobes, one-award-per-pattern locking, window expiry and an optional combo multiplier. It sits between the pattern generator and the score display/7-seg driver, clocked by the game tick.

## Interface

- PAT_W, 8: width of pattern and user_input.
- WIN_W, 3: width of the per-pattern window counter.
- PEAK, 4: window top value; must satisfy 1 <= PEAK <= 2^WIN_W-1.
- SCORE_W, 11: width of the global score.
- COMBO_W, 8: width of the combo counter.
- MULT_MAX, 4: multiplier cap (combo build only).
- counter10h  in  1  game tick clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- pattern  in  PAT_W  target pattern from the generator; 0 means blank.
- user_input  in  PAT_W  current player switch/button vector.
- score_out  out  SCORE_W  registered global score.
- hit  out  1  one-cycle pulse: pattern matched and points awarded.
- miss  out  1  one-cycle pulse: pattern expired or was replaced unresolved.
- last_points  out  SCORE_W  points of most recent hit (held).
- combo  out  COMBO_W  consecutive hits since last miss.
- state  out  2  0 IDLE, 1 RISE, 2 FALL, 3 LOCKED.

## Operation

- Registers: cur_pat (PAT_W), window (WIN_W), state, score, combo, last_points, hit, miss.
- Reset: all outputs and registers 0, state IDLE.
- Priority per edge: reset > pattern change > match > window step.
- Pattern change (pattern != cur_pat): cur_pat <= pattern, window <= 0, state <= RISE if pattern != 0 else IDLE. If the old state was RISE or FALL: miss pulse, combo <= 0. No award on this edge even if user_input matches.
- Match (state RISE or FALL, user_input == cur_pat): points = window (x multiplier if enabled); score <= min(score + points, 2^SCORE_W-1); last_points <= points; hit pulse; combo <= combo+1 saturating at 2^COMBO_W-1; state <= LOCKED. A zero-point match still counts as a hit.
- RISE, no match: window+1; on reaching PEAK, state <= FALL.
- FALL, no match: window-1; if window already 0: miss pulse, combo <= 0, state <= IDLE.
- LOCKED / IDLE: hold until pattern change; user_input ignored (no repeat awards).
- Arithmetic at SCORE_W+WIN_W+3 bits before the saturating clamp.

## Timing

- All outputs registered; response visible after the edge at which the condition is sampled.
- Latency input match -> score_out/hit: 1 edge.
- hit and miss are high for exactly one cycle and never together.
- Window profile with PEAK=4: 0,1,2,3,4,3,2,1,0, expiry on the next edge (miss 9 edges after latch).
- Reset asserted mid-window: next edge clears everything; no miss pulse.

## Configuration

- SCORE_COMBO_EN defined: points = window x mult, mult = min(1 + (combo >> 2), MULT_MAX), combo value sampled before this hit's increment.
- Not defined: points = window; combo still counted and output, multiplier logic absent.

## Test plan

- Reset, pattern 0x81 at E0, user_input 0x81 at E4 -> score_out 3, hit one cycle, last_points 3, state LOCKED; holding input 4 more ticks keeps score 3.
- Pattern 0x3C, no input -> window 0..4..0, miss pulse after E9, combo 0, state IDLE, score unchanged.
- Pattern 0x10 then 0x20 at E2 with user_input 0x10 on E2 -> no hit, miss pulse, new window starts at 0.
- SCORE_W=4, score 14, match at window 3 -> score_out 15 (saturated), last_points 3.
- SCORE_COMBO_EN, combo 4, match at window 3 -> points 6, combo 5; without macro -> points 3.
- Reset asserted at window 2 of FALL -> all outputs 0 next edge, no miss pulse.
